unified_mem_arbiter: RTL and testbench

Shares one single-ported unified instruction/data memory between the fetch stage (IF requester) and the memory stage (LS requester) of the five-stage RISC-V pipeline. It arbitrates, forwards one transaction at a time over a request/ready + response-valid memory handshake, and routes the response back to the owner. LS has priority; a starvation counter guarantees IF forward progress.

---
 rtl/unified_mem_arbiter_pkg.sv | 6 +
 rtl/unified_mem_arbiter_if.sv | 15 +
 rtl/unified_mem_arbiter.sv | 87 ++++++++
 tb/tb_unified_mem_arbiter.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/unified_mem_arbiter_pkg.sv
// mem_arb_pkg: shared FSM state and owner encodings for the unified memory arbiter
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
  localparam logic OWNER_IF = 1'b0;
  localparam logic OWNER_LS = 1'b1;
endpackage

// File: rtl/unified_mem_arbiter_if.sv
// unified_mem_arbiter_if: request/ready + response-valid bus between arbiter (master) and memory (slave)
interface unified_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ready;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;
  modport master (output mem_req, mem_we, mem_addr, mem_wdata, input mem_ready, mem_rvalid, mem_rdata);
  modport slave (input mem_req, mem_we, mem_addr, mem_wdata, output mem_ready, mem_rvalid, mem_rdata);
endinterface

// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: shares one memory port between IF and LS with LS priority and IF starvation guard
module unified_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_gnt,
  output logic              ls_rvalid,
  output logic [DATA_W-1:0] ls_rdata,
  unified_mem_arbiter_if.master mem
);
  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] SMAX = CW'(STARVE_MAX);
  state_t            r_state;
  logic              r_owner;
  logic [CW-1:0]     r_starve_cnt;
  logic              r_req;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              w_arb;
  logic              w_ls_win;
  logic              w_if_win;
  logic              w_resp;
  // LS wins whenever it asks, except when IF has been passed over STARVE_MAX times in a row
  function automatic logic pick_ls(input logic i_if, input logic i_ls, input logic [CW-1:0] i_cnt);
    return i_ls && !(i_if && i_cnt == SMAX);
  endfunction
  // Arbitration happens in IDLE and in the response cycle so back-to-back accesses lose no cycle
  always_comb begin
    w_resp    = r_state == RESP && mem.mem_rvalid;
    w_arb     = r_state == IDLE || w_resp;
    w_ls_win  = w_arb && pick_ls(if_req, ls_req, r_starve_cnt);
    w_if_win  = w_arb && if_req && !w_ls_win;
    if_gnt    = w_if_win;
    ls_gnt    = w_ls_win;
    if_rvalid = w_resp && r_owner == OWNER_IF;
    ls_rvalid = w_resp && r_owner == OWNER_LS;
    if_rdata  = mem.mem_rdata;
    ls_rdata  = mem.mem_rdata;
  end
  assign mem.mem_req   = r_req;
  assign mem.mem_we    = r_we;
  assign mem.mem_addr  = r_addr;
  assign mem.mem_wdata = r_wdata;
  // Transaction FSM: capture the winner, hold the request until accepted, then wait for the response
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_owner <= OWNER_IF;
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_ls_win || w_if_win) begin
      r_state <= REQ;
      r_owner <= w_ls_win ? OWNER_LS : OWNER_IF;
      r_req   <= 1'b1;
      r_we    <= w_ls_win && ls_we;
      r_addr  <= w_ls_win ? ls_addr : if_addr;
      r_wdata <= w_ls_win ? ls_wdata : '0;
    end else if (w_arb) begin
      r_state <= IDLE;
    end else if (r_state == REQ && mem.mem_ready) begin
      r_state <= RESP;
      r_req   <= 1'b0;
    end
  end
  // Count contested LS wins; an IF win resets the streak
  always_ff @(posedge clk) begin
    if (rst || w_if_win) r_starve_cnt <= '0;
    else if (w_ls_win && if_req) r_starve_cnt <= r_starve_cnt + 1'b1;
  end
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb_unified_mem_arbiter: directed vector table plus multi-cycle sequences for the unified memory arbiter
module tb_unified_mem_arbiter;
  import mem_arb_pkg::*;
  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, ls_req, ls_we;
  logic [31:0] if_addr, ls_addr, ls_wdata;
  logic        if_gnt, if_rvalid, ls_gnt, ls_rvalid;
  logic [31:0] if_rdata, ls_rdata;
  int          checks = 0;
  int          failures = 0;
  unified_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) mif ();
  unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
    .mem(mif)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic ir; logic [31:0] ia; logic lr; logic lw; logic [31:0] la; logic [31:0] lwd;
    logic mr; logic mv; logic [31:0] md;
    logic ig; logic lg; logic irv; logic lrv; logic mq; logic mw; logic [31:0] ma; logic [31:0] mwd;
  } vec_t;
  vec_t vecs [15];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic drive_idle();
    if_req = 0; if_addr = 0; ls_req = 0; ls_we = 0; ls_addr = 0; ls_wdata = 0;
    mif.mem_ready = 0; mif.mem_rvalid = 0; mif.mem_rdata = 0;
  endtask
  task automatic do_reset();
    drive_idle();
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
  endtask
  task automatic chk_quiet(input string name);
    chk({name, ".if_gnt"}, 32'(if_gnt), 0);
    chk({name, ".ls_gnt"}, 32'(ls_gnt), 0);
    chk({name, ".if_rvalid"}, 32'(if_rvalid), 0);
    chk({name, ".ls_rvalid"}, 32'(ls_rvalid), 0);
    chk({name, ".mem_req"}, 32'(mif.mem_req), 0);
  endtask
  initial begin
    string order;
    int    grants;
    logic  acc;
    vecs[0]  = '{1,32'h40,0,0,0,0,                1,0,0,            1,0,0,0,0,0,32'h0,0};
    vecs[1]  = '{0,32'h40,0,0,0,0,                1,0,0,            0,0,0,0,1,0,32'h40,0};
    vecs[2]  = '{0,0,0,0,0,0,                     1,1,32'h00500093, 0,0,1,0,0,0,32'h40,0};
    vecs[3]  = '{0,0,1,1,32'h100,32'hDEADBEEF,    0,0,0,            0,1,0,0,0,0,32'h40,0};
    vecs[4]  = '{0,0,0,0,0,0,                     0,0,0,            0,0,0,0,1,1,32'h100,32'hDEADBEEF};
    vecs[5]  = '{0,0,0,0,0,0,                     0,0,0,            0,0,0,0,1,1,32'h100,32'hDEADBEEF};
    vecs[6]  = '{0,0,0,0,0,0,                     0,0,0,            0,0,0,0,1,1,32'h100,32'hDEADBEEF};
    vecs[7]  = '{0,0,0,0,0,0,                     1,0,0,            0,0,0,0,1,1,32'h100,32'hDEADBEEF};
    vecs[8]  = '{0,0,0,0,0,0,                     0,0,0,            0,0,0,0,0,1,32'h100,32'hDEADBEEF};
    vecs[9]  = '{0,0,0,0,0,0,                     0,1,32'h0,        0,0,0,1,0,1,32'h100,32'hDEADBEEF};
    vecs[10] = '{0,0,1,0,32'h200,0,               1,0,0,            0,1,0,0,0,1,32'h100,32'hDEADBEEF};
    vecs[11] = '{1,32'h44,0,0,0,0,                1,0,0,            0,0,0,0,1,0,32'h200,0};
    vecs[12] = '{1,32'h44,0,0,0,0,                1,1,32'h12345678, 1,0,0,1,0,0,32'h200,0};
    vecs[13] = '{0,0,0,0,0,0,                     1,0,0,            0,0,0,0,1,0,32'h44,0};
    vecs[14] = '{0,0,0,0,0,0,                     1,1,32'h0000AAAA, 0,0,1,0,0,0,32'h44,0};
    do_reset();
    @(negedge clk);
    chk_quiet("reset");
    chk("reset.mem_we", 32'(mif.mem_we), 0);
    chk("reset.mem_addr", mif.mem_addr, 0);
    chk("reset.mem_wdata", mif.mem_wdata, 0);
    chk("reset.state", 32'(dut.r_state), 32'(IDLE));
    chk("reset.starve", 32'(dut.r_starve_cnt), 0);
    @(posedge clk); #1;
    for (int i = 0; i < 15; i++) begin
      if_req = vecs[i].ir; if_addr = vecs[i].ia;
      ls_req = vecs[i].lr; ls_we = vecs[i].lw; ls_addr = vecs[i].la; ls_wdata = vecs[i].lwd;
      mif.mem_ready = vecs[i].mr; mif.mem_rvalid = vecs[i].mv; mif.mem_rdata = vecs[i].md;
      @(negedge clk);
      chk($sformatf("v%0d.if_gnt", i), 32'(if_gnt), 32'(vecs[i].ig));
      chk($sformatf("v%0d.ls_gnt", i), 32'(ls_gnt), 32'(vecs[i].lg));
      chk($sformatf("v%0d.if_rvalid", i), 32'(if_rvalid), 32'(vecs[i].irv));
      chk($sformatf("v%0d.ls_rvalid", i), 32'(ls_rvalid), 32'(vecs[i].lrv));
      chk($sformatf("v%0d.mem_req", i), 32'(mif.mem_req), 32'(vecs[i].mq));
      chk($sformatf("v%0d.mem_we", i), 32'(mif.mem_we), 32'(vecs[i].mw));
      chk($sformatf("v%0d.mem_addr", i), mif.mem_addr, vecs[i].ma);
      chk($sformatf("v%0d.mem_wdata", i), mif.mem_wdata, vecs[i].mwd);
      chk($sformatf("v%0d.if_rdata", i), if_rdata, vecs[i].md);
      chk($sformatf("v%0d.ls_rdata", i), ls_rdata, vecs[i].md);
      @(posedge clk); #1;
    end
    drive_idle();
    repeat (2) @(posedge clk);
    #1;
    // contention: both requesters held high, memory ready always, 1-cycle response latency
    do_reset();
    if_req = 1; if_addr = 32'h80; ls_req = 1; ls_addr = 32'h300; mif.mem_ready = 1;
    order = ""; grants = 0; acc = 0;
    for (int c = 0; c < 60 && grants < 10; c++) begin
      mif.mem_rvalid = acc;
      @(negedge clk);
      if (ls_gnt) begin order = {order, "L"}; grants++; end
      if (if_gnt) begin order = {order, "I"}; grants++; end
      if (dut.r_starve_cnt > 3'd4) chk("starve.bound", 32'(dut.r_starve_cnt), 4);
      acc = mif.mem_req && mif.mem_ready;
      @(posedge clk); #1;
    end
    chk("starve.grants", grants, 10);
    checks++;
    if (order != "LLLLILLLLI") begin
      failures++;
      $display("FAIL starve.order: got %s expected LLLLILLLLI", order);
    end
    // reset while a load sits in RESP, then a stray response arrives
    do_reset();
    ls_req = 1; ls_addr = 32'h300; mif.mem_ready = 1;
    @(posedge clk); #1;
    ls_req = 0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("midresp.state", 32'(dut.r_state), 32'(RESP));
    #1 rst = 1;
    @(posedge clk); #1;
    rst = 0; mif.mem_rvalid = 1; mif.mem_rdata = 32'h55;
    @(negedge clk);
    chk_quiet("midresp");
    chk("midresp.state_after", 32'(dut.r_state), 32'(IDLE));
    chk("midresp.mem_addr", mif.mem_addr, 0);
    chk("midresp.mem_we", 32'(mif.mem_we), 0);
    @(posedge clk); #1;
    mif.mem_rvalid = 0;
    // idle stability over 20 cycles with no requests
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (if_gnt || ls_gnt || if_rvalid || ls_rvalid || mif.mem_req || dut.r_starve_cnt != 0)
        chk($sformatf("idle.c%0d", c), {if_gnt, ls_gnt, if_rvalid, ls_rvalid, mif.mem_req, 27'(dut.r_starve_cnt)}, 0);
      @(posedge clk); #1;
    end
    chk("idle.state", 32'(dut.r_state), 32'(IDLE));
    chk("idle.starve", 32'(dut.r_starve_cnt), 0);
    chk_quiet("idle.end");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
